// File: rtl/lap_timer_if.sv
// Control pulses, BCD time outputs and lap buffer read port of the lap timer core.
interface lap_timer_if #(
  parameter int LAP_DEPTH = 8
);
  localparam int CNT_W = $clog2(LAP_DEPTH) + 1;

  logic             start;
  logic             stop;
  logic             lap;
  logic             min_inc;
  logic             hour_inc;
  logic             countdown;
  logic             lap_rd;
  logic [7:0]       hours;
  logic [7:0]       minutes;
  logic [7:0]       seconds;
  logic [7:0]       centisec;
  logic             running;
  logic             expired;
  logic             lap_valid;
  logic [31:0]      lap_data;
  logic [CNT_W-1:0] lap_count;
  logic             lap_overflow;

  modport master (
    output start, stop, lap, min_inc, hour_inc, countdown, lap_rd,
    input  hours, minutes, seconds, centisec, running, expired,
           lap_valid, lap_data, lap_count, lap_overflow
  );

  modport slave (
    input  start, stop, lap, min_inc, hour_inc, countdown, lap_rd,
    output hours, minutes, seconds, centisec, running, expired,
           lap_valid, lap_data, lap_count, lap_overflow
  );
endinterface

// File: rtl/lap_timer_core.sv
// Single-clock stopwatch core: prescaled centisecond tick, count-up/countdown in BCD,
// and a first-word-fall-through lap capture buffer with sticky overflow.
//   state | meaning
//   IDLE  | stopped; time settable; mode follows countdown input
//   RUN   | counting on prescaled ticks; laps captured
//   PAUSE | halted mid-run; time settable; mode follows countdown input
//   DONE  | countdown reached zero; waiting for stop
module lap_timer_core #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 8,
  parameter int HOUR_MAX  = 99
) (
  input  logic       clk,
  input  logic       rst,
  lap_timer_if.slave io
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam int AW    = $clog2(LAP_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [7:0] HMAX = 8'(((HOUR_MAX / 10) * 16) + (HOUR_MAX % 10));

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_nxt;
  logic             mode, mode_nxt;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [31:0]      tm;
  logic [7:0]       t_h, t_m, t_s, t_c;
  logic [8:0]       up_h, up_m, up_s, up_c;
  logic [8:0]       dn_h, dn_m, dn_s, dn_c;
  logic [31:0]      up_time, dn_time;
  logic             time_zero, dn_zero, settable;

  logic [31:0]      mem [LAP_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf, push_req, push, pop, full;

  // Returns {wrap, next}: next is v+1, or 00 with wrap set when v is already max.
  function automatic logic [8:0] bcd_up(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return {1'b1, 8'h00};
    if (v[3:0] == 4'd9)    return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {borrow, next}: next is v-1, or max with borrow set when v is 00.
  function automatic logic [8:0] bcd_dn(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)        return {1'b1, max};
    if (v[3:0] == 4'd0)    return {1'b0, v[7:4] - 4'd1, 4'd9};
    return {1'b0, v[7:4], v[3:0] - 4'd1};
  endfunction

  assign {t_h, t_m, t_s, t_c} = tm;

  assign up_c = bcd_up(t_c, 8'h99);
  assign up_s = bcd_up(t_s, 8'h59);
  assign up_m = bcd_up(t_m, 8'h59);
  assign up_h = bcd_up(t_h, HMAX);
  assign dn_c = bcd_dn(t_c, 8'h99);
  assign dn_s = bcd_dn(t_s, 8'h59);
  assign dn_m = bcd_dn(t_m, 8'h59);
  assign dn_h = bcd_dn(t_h, HMAX);

  assign up_time = {(up_c[8] & up_s[8] & up_m[8]) ? up_h[7:0] : t_h,
                    (up_c[8] & up_s[8]) ? up_m[7:0] : t_m,
                    up_c[8] ? up_s[7:0] : t_s,
                    up_c[7:0]};
  // Hours never borrow: the all-zero time is caught before another tick.
  assign dn_time = {(dn_c[8] & dn_s[8] & dn_m[8]) ? dn_h[7:0] : t_h,
                    (dn_c[8] & dn_s[8]) ? dn_m[7:0] : t_m,
                    dn_c[8] ? dn_s[7:0] : t_s,
                    dn_c[7:0]};

  assign time_zero = (tm == 32'h0);
  assign dn_zero   = (dn_time == 32'h0);
  assign settable  = (state == IDLE) || (state == PAUSE);
  assign mode_nxt  = settable ? io.countdown : mode;
  assign tick      = (state == RUN) && (pre == PRE_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, PAUSE: if (io.start && !io.stop && !(mode_nxt && time_zero)) state_nxt = RUN;
      RUN:         if (io.stop) state_nxt = PAUSE;
                   else if (tick && mode && dn_zero) state_nxt = DONE;
      DONE:        if (io.stop) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.running = (state == RUN);
    io.expired = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
      pre  <= '0;
      tm   <= 32'h0;
    end else begin
      mode <= mode_nxt;
      // Outside RUN the prescaler sits at 0, so every entry to RUN starts a full period.
      if ((state == RUN) && !tick) pre <= pre + 1'b1;
      else                         pre <= '0;
      if (tick)          tm <= mode ? dn_time : up_time;
      else if (settable) tm <= {io.hour_inc ? up_h[7:0] : t_h,
                                io.min_inc  ? up_m[7:0] : t_m, t_s, t_c};
    end
  end

  assign full     = (count == CNT_W'(LAP_DEPTH));
  assign pop      = io.lap_rd && (count != '0);
  assign push_req = (state == RUN) && io.lap;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  assign io.hours        = t_h;
  assign io.minutes      = t_m;
  assign io.seconds      = t_s;
  assign io.centisec     = t_c;
  assign io.lap_valid    = (count != '0);
  assign io.lap_data     = (count != '0) ? mem[rd_ptr] : 32'h0;
  assign io.lap_count    = count;
  assign io.lap_overflow = ovf;
endmodule

// File: doc/lap_timer_core.md
Name: lap_timer_core

Overview:
Parametrised next-generation stopwatch core. It replaces the divided-clock timing path with a single-clock prescaled tick enable, and supports both count-up and countdown. It adds split/lap capture into a first-word-fall-through buffer with overflow flagging. The core sits between the debounce/edge-detect stage and the display driver, and outputs BCD time for direct display.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 100, centisecond tick rate; CLK_HZ/TICK_HZ must be an integer of at least 2
LAP_DEPTH, 8, lap buffer entries; must be a power of 2 and at least 2
HOUR_MAX, 99, maximum hour value, decimal, 1..99

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse: run/resume
stop  in  1  single-cycle pulse: pause, or acknowledge expiry
lap  in  1  single-cycle pulse: capture split time
min_inc  in  1  single-cycle pulse: minutes +1
hour_inc  in  1  single-cycle pulse: hours +1
countdown  in  1  level: 1 = countdown mode
lap_rd  in  1  single-cycle pulse: pop lap buffer head
hours  out  8  BCD hours
minutes  out  8  BCD minutes
seconds  out  8  BCD seconds
centisec  out  8  BCD centiseconds
running  out  1  high in RUN
expired  out  1  high in DONE
lap_valid  out  1  lap buffer not empty
lap_data  out  32  buffer head as {hours, minutes, seconds, centisec}
lap_count  out  clog2(LAP_DEPTH)+1  number of buffered entries
lap_overflow  out  1  sticky: a lap was dropped because the buffer was full

Behaviour:
- Reset, synchronous, highest priority:
  - state IDLE; time 00:00:00.00; prescaler 0; buffer empty; mode register 0.
  - All outputs 0.
  - lap_data is 0 while the buffer is empty.
- Prescaler and tick:
  - Counts 0..CLK_HZ/TICK_HZ-1, only in RUN.
  - Cleared to 0 on every entry to RUN.
  - tick = terminal count; the prescaler wraps to 0.
  - The first tick arrives CLK_HZ/TICK_HZ cycles after the start pulse.
- Latency: the tick cycle is N; the updated time is visible at cycle N+1. All outputs are registered.
- Mode register:
  - Loads countdown every cycle in IDLE and PAUSE.
  - Frozen in RUN and DONE.
- States:
  - IDLE: start -> RUN, unless mode=countdown and time = 00:00:00.00, in which case start is ignored.
  - RUN:
    - stop -> PAUSE.
    - Countdown tick that yields 00:00:00.00 -> DONE.
  - PAUSE: start -> RUN, with the same zero-time guard as IDLE in countdown mode.
  - DONE:
    - expired=1; time held at 0; start ignored.
    - stop -> IDLE with expired cleared.
  - start and stop in the same cycle: stop wins; start is ignored.
- Count-up arithmetic:
  - cs 99 -> 00 carries into seconds.
  - s 59 -> 00 carries into minutes.
  - m 59 -> 00 carries into hours.
  - h HOUR_MAX -> 00; the core wraps to 00:00:00.00 and keeps running.
- Countdown arithmetic:
  - cs 00 -> 99 borrows from seconds; s 00 -> 59 and m 00 -> 59 borrow likewise.
  - The tick that reaches exactly zero enters DONE; the time never underflows.
- Time setting:
  - min_inc and hour_inc act only in IDLE and PAUSE; they are ignored in RUN and DONE.
  - Minutes wrap 59 -> 00 with no carry into hours.
  - Hours wrap HOUR_MAX -> 00.
  - Seconds and centiseconds are unchanged.
  - min_inc and hour_inc in the same cycle: both apply.
- Every BCD digit stays within its legal range at all times.
- Lap capture:
  - Acts only in RUN. It pushes the time outputs as they are in that cycle, i.e. the value before any same-cycle tick update.
  - lap together with stop: the capture is pushed and the state goes to PAUSE.
- Lap buffer, FIFO, first-word-fall-through:
  - lap_data shows the oldest entry whenever lap_valid=1.
  - Pop when lap_rd=1 and lap_valid=1. lap_rd while empty is ignored.
  - Push while full: the entry is dropped and lap_overflow is set. lap_overflow stays set until rst.
  - Push and pop in the same cycle while full: both are performed; lap_count is unchanged; no overflow.
  - Push and pop in the same cycle while empty: push only.
  - lap_count goes 0..LAP_DEPTH and is exact every cycle.
- The buffer is cleared only by rst. Stop/IDLE transitions do not clear it.

Test Plan:
1. CLK_HZ=1000, TICK_HZ=100. Apply rst, then start, then wait 10 cycles -> centisec=01 one cycle after the first tick. After 6000 ticks -> 00:01:00.00.
2. Count-up from 99:59:59.99, loaded via inc pulses and preloaded ticks, then one tick -> 00:00:00.00 with running still 1.
3. countdown=1. In IDLE: 2× min_inc, then start -> after 12000 ticks the time is 00:00:00.00, expired=1 and state DONE. A further start is ignored. stop -> expired=0.
4. countdown=1 at time zero, start -> stays IDLE with running=0. stop and start in the same cycle while in RUN -> PAUSE.
5. LAP_DEPTH=4: 5 lap pulses in RUN -> lap_count=4 and lap_overflow=1. The pops return the first 4 captures in order. lap_data reads 0 after the buffer drains.
6. Buffer full, then lap and lap_rd in the same cycle -> lap_count stays 4, the head advances, and lap_overflow is unchanged. rst mid-RUN -> all outputs 0 on the next cycle.
